// File: rtl/rvvi_pkg.sv
// Purpose: shared types and ack-record layout for the RVVI host receiver and the transmit-side active list.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rvvi_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FWD  = 2'd1,
      S_ACK  = 2'd2
   } rvvi_rx_state_t;

   // Ack record layout. The transmit side decodes the same offsets.
   localparam int ACKW         = 208;
   localparam int ACK_DST_LSB  = 0;
   localparam int ACK_SRC_LSB  = 48;
   localparam int ACK_TYPE_LSB = 96;
   localparam int ACK_SEQ_LSB  = 112;
   localparam int ACK_DLY_LSB  = 176;

   // The first member sits at the MSB end, so this struct matches the offsets above.
   typedef struct packed {
      logic [31:0] dly_cnt;
      logic [63:0] seq;
      logic [15:0] eth_type;
      logic [47:0] src_mac;
      logic [47:0] dst_mac;
   } ack_rec_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/flopenl.sv
// Purpose: enabled flop with synchronous load of a non-zero value (used as a reset value).
// Latency: 1 cycle from d to q when en is high.
// Backpressure: n/a; holds q while en is low.
// Ports: clk, load, en, d[WIDTH], val[WIDTH], q[WIDTH].
module flopenl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] val,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (load)    q <= val;
      else if (en) q <= d;
   end

endmodule

// File: rtl/flopenr.sv
// Purpose: enabled flop with synchronous active-high reset to zero.
// Latency: 1 cycle from d to q when en is high.
// Backpressure: n/a; holds q while en is low.
// Ports: clk, reset, en, d[WIDTH], q[WIDTH].
module flopenr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/rvvi_ack_receiver.sv
// Purpose: host-side RVVI receiver; forwards in-order records, re-acks duplicates, drops records past a gap.
// Latency: accept to OutValid 1 cycle; in-order loop 3 cycles with OutReady=AckReady=1.
// Backpressure: InReady low while a record is held; OutValid/AckValid hold until their ready.
// Ports: clk/reset (sync, active-high); In* record input; Out* record to checker;
//        Ack* ack record to Ethernet TX; LocalMac/RemoteMac/EthType ack header fields;
//        ExpSeq/DupCount/GapCount status.
module rvvi_ack_receiver
   import rvvi_pkg::*;
#(
   parameter int          WIDTH        = 792,
   parameter int          ACKW         = rvvi_pkg::ACKW,
   parameter int          MINSTRET_LSB = 160,
   parameter logic [63:0] START_SEQ    = 64'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] InData,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] OutData,
   output logic             AckValid,
   input  logic             AckReady,
   output logic [ACKW-1:0]  AckData,
   input  logic [47:0]      LocalMac,
   input  logic [47:0]      RemoteMac,
   input  logic [15:0]      EthType,
   output logic [63:0]      ExpSeq,
   output logic [15:0]      DupCount,
   output logic [15:0]      GapCount
);

   rvvi_rx_state_t state_q, state_d;

   logic             accept;
   logic             is_dup;
   logic             is_gap;
   logic             fwd_hs;
   logic             busy;
   logic [63:0]      in_seq;
   logic [63:0]      hold_seq;
   logic [WIDTH-1:0] hold_q;
   logic [63:0]      exp_seq_q, exp_seq_d;
   logic [15:0]      dup_cnt_q, dup_cnt_d;
   logic [15:0]      gap_cnt_q, gap_cnt_d;
   logic [31:0]      dly_cnt_q, dly_cnt_d;
   logic             dly_en;
   ack_rec_t         ack_rec;

   assign in_seq   = InData[MINSTRET_LSB +: 64];
   assign hold_seq = hold_q[MINSTRET_LSB +: 64];

   assign accept = InValid & InReady;
   assign is_dup = accept & (in_seq < exp_seq_q);
   assign is_gap = accept & (in_seq > exp_seq_q);
   assign fwd_hs = OutValid & OutReady;
   assign busy   = (state_q != S_IDLE);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      InReady  = 1'b0;
      OutValid = 1'b0;
      AckValid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            InReady = 1'b1;
            // A gap leaves us in S_IDLE without an ack, so the transmitter
            // times out and replays from its tail.
            if (InValid) begin
               if (in_seq == exp_seq_q)     state_d = S_FWD;
               else if (in_seq < exp_seq_q) state_d = S_ACK;
            end
         end
         S_FWD: begin
            OutValid = 1'b1;
            if (OutReady) state_d = S_ACK;
         end
         S_ACK: begin
            AckValid = 1'b1;
            if (AckReady) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- datapath flops ----------------
   flopenr #(.WIDTH(WIDTH)) u_hold (
      .clk(clk), .reset(reset), .en(accept), .d(InData), .q(hold_q)
   );

   // ExpSeq moves only on the forward handshake; duplicates and gaps never touch it.
   assign exp_seq_d = exp_seq_q + 64'd1;
   flopenl #(.WIDTH(64)) u_exp_seq (
      .clk(clk), .load(reset), .en(fwd_hs), .d(exp_seq_d), .val(START_SEQ), .q(exp_seq_q)
   );

   assign dup_cnt_d = sat_inc16(dup_cnt_q);
   flopenr #(.WIDTH(16)) u_dup_cnt (
      .clk(clk), .reset(reset), .en(is_dup), .d(dup_cnt_d), .q(dup_cnt_q)
   );

   assign gap_cnt_d = sat_inc16(gap_cnt_q);
   flopenr #(.WIDTH(16)) u_gap_cnt (
      .clk(clk), .reset(reset), .en(is_gap), .d(gap_cnt_d), .q(gap_cnt_q)
   );

   // DelayCnt reads as the number of cycles elapsed since the accept cycle:
   // the accept edge already counts its own cycle, hence the load of 1.
   // It freezes once the ack handshake returns us to S_IDLE.
   assign dly_en    = accept | busy;
   assign dly_cnt_d = accept ? 32'd1 : sat_inc32(dly_cnt_q);
   flopenr #(.WIDTH(32)) u_dly_cnt (
      .clk(clk), .reset(reset), .en(dly_en), .d(dly_cnt_d), .q(dly_cnt_q)
   );

   // ---------------- outputs ----------------
   always_comb begin
      ack_rec          = '0;
      ack_rec.dst_mac  = RemoteMac;
      ack_rec.src_mac  = LocalMac;
      ack_rec.eth_type = EthType;
      ack_rec.seq      = hold_seq;
      ack_rec.dly_cnt  = dly_cnt_q;
   end

   assign AckData  = ack_rec;
   assign OutData  = hold_q;
   assign ExpSeq   = exp_seq_q;
   assign DupCount = dup_cnt_q;
   assign GapCount = gap_cnt_q;

endmodule
